// File: rtl/interval_timer_ctrl_if.sv
// Sequencer <-> interval timer bundle: start/select, reprogram strobe, status.
// master = sequencer side, slave = timer side.
interface interval_timer_ctrl_if;
    logic       Start_Timer;
    logic [1:0] Interval;
    logic       Sync_Reprogram;
    logic [1:0] Time_Param_Sel;
    logic [3:0] Time_Value;
    logic       Expired;
    logic       Busy;
    logic [3:0] Remaining;
    logic       Tick;

    modport master (
        output Start_Timer,
        output Interval,
        output Sync_Reprogram,
        output Time_Param_Sel,
        output Time_Value,
        input  Expired,
        input  Busy,
        input  Remaining,
        input  Tick
    );

    modport slave (
        input  Start_Timer,
        input  Interval,
        input  Sync_Reprogram,
        input  Time_Param_Sel,
        input  Time_Value,
        output Expired,
        output Busy,
        output Remaining,
        output Tick
    );
endinterface

// File: rtl/interval_timer_ctrl.sv
// Seconds-based interval timer with run-time programmable durations.
// Optional walk duration register enabled by TIMER_WALK_PARAM_EN.
module interval_timer_ctrl #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int T_BASE_DEF    = 6,
    parameter int T_EXT_DEF     = 3,
    parameter int T_YEL_DEF     = 2,
    parameter int T_WALK_DEF    = 4
) (
    input  logic                  clk,
    input  logic                  Reset_n,
    interval_timer_ctrl_if.slave  bus
);

    localparam int PW = $clog2(TICKS_PER_SEC);

    if (TICKS_PER_SEC < 2 || T_BASE_DEF > 15 || T_EXT_DEF > 15 ||
        T_YEL_DEF > 15 || T_WALK_DEF > 15 || T_WALK_DEF < 0) begin : g_bad_param
        $error("interval_timer_ctrl: parameter out of range");
    end

    typedef enum logic {
        S_IDLE,
        S_COUNT
    } state_t;

    state_t          r_state;
    logic            r_start_q;
    logic [PW-1:0]   r_presc;
    logic [3:0]      r_rem;
    logic            r_exp;
    logic            r_busy;
    logic            r_tick;
    logic [3:0]      r_dur_base;
    logic [3:0]      r_dur_ext;
    logic [3:0]      r_dur_yel;
`ifdef TIMER_WALK_PARAM_EN
    logic [3:0]      r_dur_walk;
`endif

    logic            w_start_rise;
    logic [1:0]      w_ld_idx;
    logic            w_wr_hit;
    logic [3:0]      w_dur_sel;
    logic [3:0]      w_ld_raw;
    logic [3:0]      w_ld_val;
    logic            w_tick;
    logic            w_presc_wrap;

    assign w_start_rise = bus.Start_Timer & ~r_start_q;

`ifdef TIMER_WALK_PARAM_EN
    assign w_ld_idx = bus.Interval;
`else
    assign w_ld_idx = (bus.Interval == 2'b11) ? 2'b00 : bus.Interval;
`endif

    always_comb begin
        w_dur_sel = r_dur_base;
        case (w_ld_idx)
            2'b01:   w_dur_sel = r_dur_ext;
            2'b10:   w_dur_sel = r_dur_yel;
`ifdef TIMER_WALK_PARAM_EN
            2'b11:   w_dur_sel = r_dur_walk;
`endif
            default: w_dur_sel = r_dur_base;
        endcase
    end

    // A write landing in the load cycle for the same slot is forwarded.
    assign w_wr_hit = bus.Sync_Reprogram && (bus.Time_Param_Sel == w_ld_idx);
    assign w_ld_raw = w_wr_hit ? bus.Time_Value : w_dur_sel;
    assign w_ld_val = (w_ld_raw == 4'd0) ? 4'd1 : w_ld_raw;

    // Decide one cycle early so the registered Expired lands on the boundary.
    assign w_tick       = (r_state == S_COUNT) &&
                          (r_presc == PW'(TICKS_PER_SEC - 2));
    assign w_presc_wrap = (r_presc == PW'(TICKS_PER_SEC - 1));

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_dur_base <= 4'(T_BASE_DEF);
            r_dur_ext  <= 4'(T_EXT_DEF);
            r_dur_yel  <= 4'(T_YEL_DEF);
`ifdef TIMER_WALK_PARAM_EN
            r_dur_walk <= 4'(T_WALK_DEF);
`endif
        end else if (bus.Sync_Reprogram) begin
            case (bus.Time_Param_Sel)
                2'b00:   r_dur_base <= bus.Time_Value;
                2'b01:   r_dur_ext  <= bus.Time_Value;
                2'b10:   r_dur_yel  <= bus.Time_Value;
`ifdef TIMER_WALK_PARAM_EN
                2'b11:   r_dur_walk <= bus.Time_Value;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_presc   <= '0;
            r_rem     <= 4'd0;
            r_exp     <= 1'b0;
            r_busy    <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_start_q <= bus.Start_Timer;
            r_exp     <= 1'b0;
            r_tick    <= 1'b0;
            if (w_start_rise) begin
                r_state <= S_COUNT;
                r_busy  <= 1'b1;
                r_rem   <= w_ld_val;
                r_presc <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_busy  <= 1'b0;
                        r_presc <= '0;
                    end
                    S_COUNT: begin
                        r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;
                        if (w_tick) begin
                            r_tick <= 1'b1;
                            if (r_rem > 4'd1) begin
                                r_rem <= r_rem - 4'd1;
                            end else begin
                                r_rem   <= 4'd0;
                                r_exp   <= 1'b1;
                                r_busy  <= 1'b0;
                                r_presc <= '0;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.Expired   = r_exp;
    assign bus.Busy      = r_busy;
    assign bus.Remaining = r_rem;
    assign bus.Tick      = r_tick;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl (TICKS_PER_SEC=4).
// Elapsed-time model plus directed literal checks and random traffic.
module tb_interval_timer_ctrl;

    localparam int TPS = 4;
`ifdef TIMER_WALK_PARAM_EN
    localparam bit WALK = 1'b1;
`else
    localparam bit WALK = 1'b0;
`endif

    logic clk;
    logic Reset_n;
    int   n_chk;
    int   n_err;
    bit   armed;

    interval_timer_ctrl_if ifc();

    interval_timer_ctrl #(.TICKS_PER_SEC(TPS)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: remember when the current countdown was loaded and for how long.
    int       cyc;
    int       m_s;
    int       m_d;
    bit       m_act;
    bit       m_prev;
    int       m_dur [4];

    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_act  = 1'b0;
            m_prev = 1'b0;
            m_dur  = '{6, 3, 2, 4};
        end else begin
            int idx;
            bit rise;
            rise = ifc.Start_Timer && !m_prev;
            if (ifc.Sync_Reprogram && (ifc.Time_Param_Sel != 2'd3 || WALK))
                m_dur[ifc.Time_Param_Sel] = int'(ifc.Time_Value);
            if (rise) begin
                idx = int'(ifc.Interval);
                if (idx == 3 && !WALK) idx = 0;
                m_d   = (m_dur[idx] == 0) ? 1 : m_dur[idx];
                m_s   = cyc;
                m_act = 1'b1;
            end
            m_prev = ifc.Start_Timer;
            cyc++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            int e_exp, e_busy, e_rem, e_tick, e, t;
            e_exp = 0; e_busy = 0; e_rem = 0; e_tick = 0;
            if (Reset_n && m_act) begin
                e = cyc - m_s;
                t = m_d * TPS;
                if (e < t) begin
                    e_busy = 1;
                    e_rem  = m_d - e / TPS;
                    e_tick = (e % TPS == 0) ? 1 : 0;
                end else if (e == t) begin
                    e_exp  = 1;
                    e_tick = 1;
                end
            end
            chk("model_expired",   int'(ifc.Expired),   e_exp);
            chk("model_busy",      int'(ifc.Busy),      e_busy);
            chk("model_remaining", int'(ifc.Remaining), e_rem);
            chk("model_tick",      int'(ifc.Tick),      e_tick);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] iv);
        ifc.Interval    = iv;
        ifc.Start_Timer = 1'b1;
        step();
        ifc.Start_Timer = 1'b0;
    endtask

    task automatic write(input logic [1:0] sel, input logic [3:0] v);
        ifc.Sync_Reprogram = 1'b1;
        ifc.Time_Param_Sel = sel;
        ifc.Time_Value     = v;
        step();
        ifc.Sync_Reprogram = 1'b0;
    endtask

    // Entered just after the edge starting cycle n0 (relative to load).
    task automatic wait_exp(input int n0, output int n);
        n = n0;
        while (n < 200) begin
            @(negedge clk);
            if (ifc.Expired === 1'b1) break;
            step();
            n++;
        end
    endtask

    initial begin
        int n, cnt, first;
        n_chk = 0;
        n_err = 0;
        armed = 1'b0;
        cyc   = 0;
        m_s   = 0;
        m_d   = 1;
        ifc.Start_Timer    = 1'b0;
        ifc.Interval       = 2'b00;
        ifc.Sync_Reprogram = 1'b0;
        ifc.Time_Param_Sel = 2'b00;
        ifc.Time_Value     = 4'd0;
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        repeat (2) step();
        armed = 1'b1;
        @(negedge clk);
        chk("reset_busy", int'(ifc.Busy), 0);
        chk("reset_rem",  int'(ifc.Remaining), 0);
        step();
        Reset_n = 1'b1;
        step();

        // Base countdown: 6 s -> 24 cycles
        start(2'b00);
        @(negedge clk);
        chk("t1_rem_load", int'(ifc.Remaining), 6);
        chk("t1_busy",     int'(ifc.Busy), 1);
        step();
        wait_exp(2, n);
        chk("t1_exp_cycle", n, 24);
        chk("t1_busy_after", int'(ifc.Busy), 0);
        step();
        @(negedge clk);
        chk("t1_exp_single", int'(ifc.Expired), 0);
        step();

        // Start held high for 15 cycles: one yellow count only
        ifc.Interval    = 2'b10;
        ifc.Start_Timer = 1'b1;
        cnt = 0;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 15) ifc.Start_Timer = 1'b0;
            @(negedge clk);
            if (ifc.Expired === 1'b1) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
        chk("t2_exp_count", cnt, 1);
        chk("t2_exp_cycle", first, 8);
        step();

        // Restart at Remaining=2 of an ext count
        start(2'b01);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (ifc.Remaining == 4'd2) break;
            step();
            n++;
        end
        chk("t3_reached_rem2", int'(ifc.Remaining), 2);
        step();
        start(2'b10);
        @(negedge clk);
        chk("t3_rem_reload", int'(ifc.Remaining), 2);
        step();
        wait_exp(2, n);
        chk("t3_exp_cycle", n, 8);
        step();

        // Reprogram during a count; write-through on same-cycle load
        start(2'b00);
        repeat (3) step();
        write(2'b00, 4'd9);
        wait_exp(5, n);
        chk("t4_old_dur_exp", n, 24);
        step();
        start(2'b00);
        @(negedge clk);
        chk("t4_new_base", int'(ifc.Remaining), 9);
        step();
        ifc.Sync_Reprogram = 1'b1;
        ifc.Time_Param_Sel = 2'b01;
        ifc.Time_Value     = 4'd5;
        start(2'b01);
        ifc.Sync_Reprogram = 1'b0;
        @(negedge clk);
        chk("t4_write_through", int'(ifc.Remaining), 5);
        step();

        // Zero duration behaves as 1 s
        write(2'b10, 4'd0);
        start(2'b10);
        @(negedge clk);
        chk("t5_zero_rem", int'(ifc.Remaining), 1);
        step();
        wait_exp(2, n);
        chk("t5_zero_exp", n, 4);
        step();

        // Asynchronous reset mid-count restores defaults
        start(2'b00);
        repeat (5) step();
        Reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", int'(ifc.Busy), 0);
        chk("t5_rst_rem",  int'(ifc.Remaining), 0);
        chk("t5_rst_exp",  int'(ifc.Expired), 0);
        chk("t5_rst_tick", int'(ifc.Tick), 0);
        step();
        step();
        Reset_n = 1'b1;
        step();
        start(2'b00);
        @(negedge clk);
        chk("t5_base_default", int'(ifc.Remaining), 6);
        step();
        start(2'b10);
        @(negedge clk);
        chk("t5_yel_default", int'(ifc.Remaining), 2);
        step();

        // Interval 11 and Sel 11
        start(2'b11);
        @(negedge clk);
        chk("t6_int11_before", int'(ifc.Remaining), WALK ? 4 : 6);
        step();
        write(2'b11, 4'd7);
        start(2'b11);
        @(negedge clk);
        chk("t6_int11_after", int'(ifc.Remaining), WALK ? 7 : 6);
        step();
        start(2'b00);
        @(negedge clk);
        chk("t6_base_intact", int'(ifc.Remaining), 6);
        step();

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if (ifc.Start_Timer)
                ifc.Start_Timer = ($urandom_range(0, 2) != 0);
            else
                ifc.Start_Timer = ($urandom_range(0, 49) == 0);
            ifc.Interval       = 2'($urandom_range(0, 3));
            ifc.Sync_Reprogram = ($urandom_range(0, 9) == 0);
            ifc.Time_Param_Sel = 2'($urandom_range(0, 3));
            ifc.Time_Value     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1499) == 0) begin
                Reset_n = 1'b0;
                step();
                step();
                Reset_n = 1'b1;
            end
            step();
        end
        ifc.Start_Timer    = 1'b0;
        ifc.Sync_Reprogram = 1'b0;
        repeat (3) step();
        armed = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
